// File: rtl/myproject_hls_deadlock_report_unit.sv
`default_nettype none
// ============================================================================
// Module   : myproject_hls_deadlock_report_unit
// Brief    : Debounces deadlock-monitor block signals, latches one timestamped
//            report, offers it over valid/ready and keeps a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module myproject_hls_deadlock_report_unit #(
  parameter int NUM_MONITORS = 1,
  parameter int THRESHOLD    = 64,
  parameter int CNT_W        = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_MONITORS-1:0] block_in,
  input  logic                    clear,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [NUM_MONITORS-1:0] report_src,
  output logic [CNT_W-1:0]        report_time,
  output logic                    deadlock_detected,
  output logic                    busy_watch
);

  localparam logic [15:0]      c_THRESHOLD = 16'(THRESHOLD);
  localparam logic [CNT_W-1:0] c_CYC_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cyc_cnt;
  logic [CNT_W-1:0]        r_run_start;
  logic [15:0]             r_run_cnt;
  logic [NUM_MONITORS-1:0] r_src_acc;

  logic        w_any_blk;
  logic [15:0] w_run_next;

  assign w_any_blk  = |block_in;
  assign w_run_next = r_run_cnt + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_cyc_cnt         <= '0;
      r_run_start       <= '0;
      r_run_cnt         <= '0;
      r_src_acc         <= '0;
      report_valid      <= 1'b0;
      report_src        <= '0;
      report_time       <= '0;
      deadlock_detected <= 1'b0;
      busy_watch        <= 1'b0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + c_CYC_ONE;
      if (clear) begin
        r_state           <= ST_IDLE;
        r_run_cnt         <= '0;
        r_src_acc         <= '0;
        report_valid      <= 1'b0;
        report_src        <= '0;
        report_time       <= '0;
        deadlock_detected <= 1'b0;
        busy_watch        <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any_blk) begin
              r_state     <= ST_WATCH;
              r_run_cnt   <= 16'd1;
              r_src_acc   <= block_in;
              // The report timestamp marks the first sample of the run.
              r_run_start <= r_cyc_cnt;
              busy_watch  <= 1'b1;
            end
          end
          ST_WATCH: begin
            if (!w_any_blk) begin
              r_state    <= ST_IDLE;
              r_run_cnt  <= '0;
              r_src_acc  <= '0;
              busy_watch <= 1'b0;
            end else if (w_run_next == c_THRESHOLD) begin
              r_state           <= ST_REPORT;
              r_run_cnt         <= w_run_next;
              r_src_acc         <= r_src_acc | block_in;
              report_src        <= r_src_acc | block_in;
              report_time       <= r_run_start;
              report_valid      <= 1'b1;
              deadlock_detected <= 1'b1;
              busy_watch        <= 1'b0;
            end else begin
              r_run_cnt <= w_run_next;
              r_src_acc <= r_src_acc | block_in;
            end
          end
          ST_REPORT: begin
            if (report_ready) begin
              r_state      <= ST_LATCHED;
              report_valid <= 1'b0;
            end
          end
          default: begin
            // Latched: nothing changes until clear or reset.
            r_state <= ST_LATCHED;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_myproject_hls_deadlock_report_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_myproject_hls_deadlock_report_unit
// Brief    : Directed vector table plus corner sequences for the report unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_hls_deadlock_report_unit;

  logic       clock;
  logic       reset;
  logic [1:0] block_in;
  logic       clear;
  logic       report_valid;
  logic       report_ready;
  logic [1:0] report_src;
  logic [7:0] report_time;
  logic       deadlock_detected;
  logic       busy_watch;

  int checks;
  int failures;
  int ecnt;

  myproject_hls_deadlock_report_unit #(
    .NUM_MONITORS(2),
    .THRESHOLD   (4),
    .CNT_W       (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .block_in         (block_in),
    .clear            (clear),
    .report_valid     (report_valid),
    .report_ready     (report_ready),
    .report_src       (report_src),
    .report_time      (report_time),
    .deadlock_detected(deadlock_detected),
    .busy_watch       (busy_watch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] blk;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic       e_dd;
    logic       e_busy;
    logic [1:0] e_src;
    logic [7:0] e_time;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic d, input logic b,
                           input logic [1:0] s, input logic [7:0] t);
    check({tag, ".valid"}, 32'(report_valid), 32'(v));
    check({tag, ".dd"},    32'(deadlock_detected), 32'(d));
    check({tag, ".busy"},  32'(busy_watch), 32'(b));
    check({tag, ".src"},   32'(report_src), 32'(s));
    check({tag, ".time"},  32'(report_time), 32'(t));
  endtask

  // Inputs change 1 time unit after an edge and are sampled at the next edge.
  task automatic drive(input logic [1:0] b, input logic r, input logic c);
    block_in     = b;
    report_ready = r;
    clear        = c;
    @(posedge clock);
    #1;
    ecnt++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ecnt     = 0;
    reset        = 1'b1;
    block_in     = 2'b00;
    clear        = 1'b0;
    report_ready = 1'b0;

    //               blk   rdy   clr   val   dd    busy  src    time
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0};
    for (int i = 4; i < 10; i++)
      vecs[i] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0};
    vecs[10] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[11] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[12] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[13] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 8'd10};
    vecs[14] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10};
    vecs[15] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10};
    vecs[16] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10};

    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    reset = 1'b0;

    // Short run then idle padding, then the edge 10..13 qualifying run.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].blk, vecs[i].rdy, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_dd, vecs[i].e_busy,
                vecs[i].e_src, vecs[i].e_time);
    end

    // Clear out of LATCHED, then a stalled report (edges 18..21).
    drive(2'b00, 1'b0, 1'b1);
    check_all("clear1", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    repeat (3) drive(2'b01, 1'b0, 1'b0);
    check_all("run2_pre", 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);
    drive(2'b01, 1'b0, 1'b0);
    check_all("run2_decl", 1'b1, 1'b1, 1'b0, 2'b01, 8'd18);
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 1'b0, 1'b0);
      check_all($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 2'b01, 8'd18);
    end
    drive(2'b11, 1'b1, 1'b0);
    check_all("accept2", 1'b0, 1'b1, 1'b0, 2'b01, 8'd18);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0);
      check_all($sformatf("latched%0d", i), 1'b0, 1'b1, 1'b0, 2'b01, 8'd18);
    end

    // Clear and acceptance in the same cycle: clear wins.
    drive(2'b00, 1'b0, 1'b1);
    repeat (4) drive(2'b10, 1'b0, 1'b0);
    check_all("run3_decl", 1'b1, 1'b1, 1'b0, 2'b10, 8'(ecnt - 4));
    drive(2'b10, 1'b1, 1'b1);
    check_all("clr_acc", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    drive(2'b00, 1'b0, 1'b0);
    check_all("clr_acc_idle", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);

    // Counter wrap: run from edge 254, then a run from edge 260 (wraps to 4).
    while (ecnt < 254) drive(2'b00, 1'b0, 1'b0);
    repeat (4) drive(2'b01, 1'b0, 1'b0);
    check_all("wrap_254", 1'b1, 1'b1, 1'b0, 2'b01, 8'd254);
    drive(2'b00, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 1'b1);
    repeat (4) drive(2'b01, 1'b0, 1'b0);
    check_all("wrap_260", 1'b1, 1'b1, 1'b0, 2'b01, 8'd4);

    // Asynchronous reset in the middle of a cycle while REPORT is pending.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    block_in = 2'b00;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ecnt  = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b0);
      check_all($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
